// File: rtl/lock_supervisor_if.sv
// Keypad-side bundle for lock_supervisor: digit handshake, control requests and status outputs.
// The slave modport is the supervisor; the master modport is the keypad/status side driving it.
interface lock_supervisor_if #(
    parameter int MAX_FAILS = 3
);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic              i_key_valid;
    logic [3:0]        i_key_digit;
    logic              o_key_ready;
    logic              i_cancel;
    logic              i_prog;
    logic              o_unlocked;
    logic              o_locked_out;
    logic              o_attempt_fail;
    logic              o_prog_done;
    logic [FAIL_W-1:0] o_fail_count;

    modport slave (
        input  i_key_valid, i_key_digit, i_cancel, i_prog,
        output o_key_ready, o_unlocked, o_locked_out, o_attempt_fail, o_prog_done, o_fail_count
    );

    modport master (
        output i_key_valid, i_key_digit, i_cancel, i_prog,
        input  o_key_ready, o_unlocked, o_locked_out, o_attempt_fail, o_prog_done, o_fail_count
    );
endinterface

// File: rtl/lock_supervisor.sv
// Combination-lock attempt sequencer: digit collection, code check, unlock window, failure lockout.
// Define LOCK_PROG_EN to allow reprogramming the code from the unlock window (PROG state).
module lock_supervisor #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] CODE           = 16'h9979,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 1000,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    ENTRY_TIMEOUT  = 2000
) (
    input logic            clk,
    input logic            rst_n,
    lock_supervisor_if.slave bus
);
    localparam int BW     = 4 * CODE_LEN;
    localparam int CNT_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int T_AB   = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int T_MAX  = (T_AB > ENTRY_TIMEOUT) ? T_AB : ENTRY_TIMEOUT;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT,
        ST_PROG
    } state_t;

    state_t            r_state;
    logic [BW-1:0]     r_buf;
    logic [CNT_W-1:0]  r_count;
    logic [TW-1:0]     r_timer;
    logic [FAIL_W-1:0] r_fail_count;
    logic              r_ready_en;
    logic              r_unlocked;
    logic              r_locked_out;
    logic              r_attempt_fail;

    logic              w_key_ready;
    logic              w_accept;
    logic [BW-1:0]     w_shifted;
    logic [BW-1:0]     w_code;
    logic              w_commit;

`ifdef LOCK_PROG_EN
    logic [BW-1:0]     r_code;
    logic              r_prog_done;
    logic              r_prog_commit;

    assign w_code   = r_code;
    assign w_commit = r_prog_commit;
    assign bus.o_prog_done = r_prog_done;
`else
    logic              w_unused_prog;

    assign w_code   = CODE;
    assign w_commit = 1'b0;
    assign w_unused_prog = bus.i_prog;
    assign bus.o_prog_done = 1'b0;
`endif

    // r_ready_en holds key_ready low through reset and for the first clock after release.
    assign w_key_ready = r_ready_en && !bus.i_cancel &&
                         (r_state == ST_IDLE || r_state == ST_COLLECT || r_state == ST_PROG);
    assign w_accept    = bus.i_key_valid && w_key_ready;
    assign w_shifted   = (r_buf << 4) | BW'(bus.i_key_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_buf          <= '0;
            r_count        <= '0;
            r_timer        <= '0;
            r_fail_count   <= '0;
            r_ready_en     <= 1'b0;
            r_unlocked     <= 1'b0;
            r_locked_out   <= 1'b0;
            r_attempt_fail <= 1'b0;
`ifdef LOCK_PROG_EN
            r_code         <= CODE;
            r_prog_done    <= 1'b0;
            r_prog_commit  <= 1'b0;
`endif
        end else begin
            r_ready_en     <= 1'b1;
            r_attempt_fail <= 1'b0;
`ifdef LOCK_PROG_EN
            r_prog_done    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if (bus.i_cancel) begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_buf   <= w_shifted;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                        if (r_count == LAST_IDX) begin
                            r_state <= ST_CHECK;
                            r_count <= '0;
                        end else begin
                            r_state <= ST_COLLECT;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else if (r_state == ST_COLLECT) begin
                        if (r_timer == TW'(1)) begin
                            r_state <= ST_IDLE;
                            r_buf   <= '0;
                            r_count <= '0;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                end

                // A completed PROG entry also passes through here, committing instead of comparing.
                ST_CHECK: begin
                    r_buf <= '0;
                    if (w_commit) begin
`ifdef LOCK_PROG_EN
                        r_code        <= r_buf;
                        r_prog_done   <= 1'b1;
                        r_prog_commit <= 1'b0;
`endif
                        r_state <= ST_IDLE;
                    end else if (r_buf == w_code) begin
                        r_state      <= ST_OPEN;
                        r_unlocked   <= 1'b1;
                        r_fail_count <= '0;
                        r_timer      <= TW'(UNLOCK_CYCLES);
                    end else if (int'(r_fail_count) + 1 >= MAX_FAILS) begin
                        r_state      <= ST_LOCKOUT;
                        r_locked_out <= 1'b1;
                        r_fail_count <= FAIL_W'(MAX_FAILS);
                        r_timer      <= TW'(LOCKOUT_CYCLES);
                    end else begin
                        r_state        <= ST_IDLE;
                        r_fail_count   <= r_fail_count + FAIL_W'(1);
                        r_attempt_fail <= 1'b1;
                    end
                end

                ST_OPEN: begin
                    if (bus.i_cancel) begin
                        r_state    <= ST_IDLE;
                        r_unlocked <= 1'b0;
`ifdef LOCK_PROG_EN
                    end else if (bus.i_prog) begin
                        r_state    <= ST_PROG;
                        r_unlocked <= 1'b0;
                        r_buf      <= '0;
                        r_count    <= '0;
                        r_timer    <= TW'(ENTRY_TIMEOUT);
`endif
                    end else if (r_timer == TW'(1)) begin
                        r_state    <= ST_IDLE;
                        r_unlocked <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (r_timer == TW'(1)) begin
                        r_state      <= ST_IDLE;
                        r_locked_out <= 1'b0;
                        r_fail_count <= '0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end

`ifdef LOCK_PROG_EN
                // Aborting PROG leaves r_code untouched and counts no failure.
                ST_PROG: begin
                    if (bus.i_cancel) begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_buf   <= w_shifted;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                        if (r_count == LAST_IDX) begin
                            r_state       <= ST_CHECK;
                            r_prog_commit <= 1'b1;
                            r_count       <= '0;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else if (r_timer == TW'(1)) begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_count <= '0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_key_ready    = w_key_ready;
    assign bus.o_unlocked     = r_unlocked;
    assign bus.o_locked_out   = r_locked_out;
    assign bus.o_attempt_fail = r_attempt_fail;
    assign bus.o_fail_count   = r_fail_count;
endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor in its default build (LOCK_PROG_EN undefined).
// Cycle vectors cover unlock, failures/lockout and cancel; hand sequences cover timeout and reset.
module tb_lock_supervisor;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   failCount;

   lock_supervisor_if #(.MAX_FAILS(3)) bus ();

   lock_supervisor #(
      .CODE_LEN       (4),
      .CODE           (16'h9979),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (20),
      .UNLOCK_CYCLES  (10),
      .ENTRY_TIMEOUT  (15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock; stimulus changes on falling edges, checks sample there too.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       valid;
      logic [3:0] digit;
      logic       cancel;
      logic       prog;
      logic       expReady;
      logic       expUnlocked;
      logic       expLockedOut;
      logic       expAttemptFail;
      logic [1:0] expFailCount;
   } vec_t;

   vec_t vecs[$];

   // Each vector's inputs are held for one clock; expectations are the outputs after that edge.
   function automatic void addVec(input logic v, input logic [3:0] d, input logic c, input logic p,
                                  input logic er, input logic eu, input logic el, input logic ea,
                                  input logic [1:0] efc);
      vec_t t;
      t.valid = v; t.digit = d; t.cancel = c; t.prog = p;
      t.expReady = er; t.expUnlocked = eu; t.expLockedOut = el;
      t.expAttemptFail = ea; t.expFailCount = efc;
      vecs.push_back(t);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.i_key_valid = v.valid;
      bus.i_key_digit = v.digit;
      bus.i_cancel    = v.cancel;
      bus.i_prog      = v.prog;
   endtask

   task automatic checkAll(input string tag, input logic er, input logic eu, input logic el,
                           input logic ea, input logic [1:0] efc);
      checkOutput({tag, ".key_ready"},    8'(bus.o_key_ready),    8'(er));
      checkOutput({tag, ".unlocked"},     8'(bus.o_unlocked),     8'(eu));
      checkOutput({tag, ".locked_out"},   8'(bus.o_locked_out),   8'(el));
      checkOutput({tag, ".attempt_fail"}, 8'(bus.o_attempt_fail), 8'(ea));
      checkOutput({tag, ".prog_done"},    8'(bus.o_prog_done),    8'd0);
      checkOutput({tag, ".fail_count"},   8'(bus.o_fail_count),   8'(efc));
   endtask

   // Offer one digit for one clock; returns at the falling edge after the accepting edge.
   task automatic sendDigit(input logic [3:0] d);
      bus.i_key_valid = 1'b1;
      bus.i_key_digit = d;
      @(negedge clk);
      bus.i_key_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseCancel();
      bus.i_cancel = 1'b1;
      @(negedge clk);
      bus.i_cancel = 1'b0;
   endtask

   // Four digits, then one clock so the CHECK cycle resolves.
   task automatic sendCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      sendDigit(a);
      sendDigit(b);
      sendDigit(c);
      sendDigit(d);
      idleCycles(1);
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      bus.i_key_valid = 1'b0;
      bus.i_key_digit = 4'h0;
      bus.i_cancel    = 1'b0;
      bus.i_prog      = 1'b0;
      rst_n = 1'b1;

      // Correct code, with prog held through the window to show it is ignored in this build.
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 7, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) addVec(0, 0, 0, 1, 0, 1, 0, 0, 0);
      addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Three wrong attempts: two attempt_fail pulses, then a 20-clock lockout.
      for (int a = 0; a < 3; a++) begin
         addVec(1, 1, 0, 0, 1, 0, 0, 0, 2'(a));
         addVec(1, 2, 0, 0, 1, 0, 0, 0, 2'(a));
         addVec(1, 3, 0, 0, 1, 0, 0, 0, 2'(a));
         addVec(1, 4, 0, 0, 0, 0, 0, 0, 2'(a));
         if (a < 2) addVec(0, 0, 0, 0, 1, 0, 0, 1, 2'(a + 1));
         else       addVec(0, 0, 0, 0, 0, 0, 1, 0, 2'd3);
      end
      for (int k = 0; k < 19; k++) addVec(1, 9, logic'(k == 5), 0, 0, 0, 1, 0, 3);
      addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 7, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 0, 0, 0, 0);
      addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Cancel beats a same-cycle digit; the following 7,9 must not complete an attempt.
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 7, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 7, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);
      addVec(0, 0, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 7, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 9, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
      addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Reset state, including key_ready low during reset and for the first clock after.
      #2 rst_n = 1'b0;
      idleCycles(2);
      checkAll("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1 checkOutput("release.key_ready", 8'(bus.o_key_ready), 8'd0);
      @(negedge clk);
      checkOutput("first_clk.key_ready", 8'(bus.o_key_ready), 8'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkAll($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expUnlocked,
                  vecs[i].expLockedOut, vecs[i].expAttemptFail, vecs[i].expFailCount);
      end
      applyStimulus('{valid: 0, digit: 0, cancel: 0, prog: 0, expReady: 0, expUnlocked: 0,
                      expLockedOut: 0, expAttemptFail: 0, expFailCount: 0});

      // Entry timeout: 9,9,7 then 15 idle clocks discards the partial entry.
      sendDigit(9);
      sendDigit(9);
      sendDigit(7);
      idleCycles(15);
      sendDigit(9);
      checkOutput("timeout.key_ready", 8'(bus.o_key_ready), 8'd1);
      idleCycles(1);
      checkOutput("timeout.unlocked", 8'(bus.o_unlocked), 8'd0);
      checkOutput("timeout.fail_count", 8'(bus.o_fail_count), 8'd0);
      sendDigit(9);
      sendDigit(7);
      sendDigit(9);
      idleCycles(1);
      checkOutput("after_timeout.unlocked", 8'(bus.o_unlocked), 8'd1);
      pulseCancel();

      // One clock short of the timeout, the partial entry survives.
      sendDigit(9);
      sendDigit(9);
      sendDigit(7);
      idleCycles(14);
      sendDigit(9);
      checkOutput("no_timeout.key_ready", 8'(bus.o_key_ready), 8'd0);
      idleCycles(1);
      checkOutput("no_timeout.unlocked", 8'(bus.o_unlocked), 8'd1);
      checkOutput("no_timeout.fail_count", 8'(bus.o_fail_count), 8'd0);

      // Asynchronous reset in the middle of the unlock window.
      idleCycles(3);
      checkOutput("mid_open.unlocked", 8'(bus.o_unlocked), 8'd1);
      rst_n = 1'b0;
      #1 checkAll("reset_open", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("open_release.key_ready", 8'(bus.o_key_ready), 8'd0);
      @(negedge clk);
      checkOutput("open_release_clk.key_ready", 8'(bus.o_key_ready), 8'd1);

      // Asynchronous reset in the middle of a lockout.
      sendCode(1, 2, 3, 4);
      sendCode(5, 6, 7, 8);
      checkOutput("pre_lock.fail_count", 8'(bus.o_fail_count), 8'd2);
      sendCode(0, 0, 0, 0);
      idleCycles(5);
      checkOutput("mid_lock.locked_out", 8'(bus.o_locked_out), 8'd1);
      checkOutput("mid_lock.fail_count", 8'(bus.o_fail_count), 8'd3);
      checkOutput("mid_lock.key_ready", 8'(bus.o_key_ready), 8'd0);
      rst_n = 1'b0;
      #1 checkAll("reset_lock", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("lock_release.key_ready", 8'(bus.o_key_ready), 8'd0);
      @(negedge clk);
      checkOutput("lock_release_clk.key_ready", 8'(bus.o_key_ready), 8'd1);
      sendCode(9, 9, 7, 9);
      checkOutput("post_reset.unlocked", 8'(bus.o_unlocked), 8'd1);
      checkOutput("post_reset.fail_count", 8'(bus.o_fail_count), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
